decode_stage: RTL and testbench

Pipelined RV32 instruction decode stage between instruction fetch and the execute stage. It accepts one fetched instruction per valid/ready handshake and decodes it into the team's shared control encodings: ALU operation, ALU operand source and register write-data source. It also extracts register indices and a sign-extended immediate, and presents everything from a registered ID/EX output with a valid/ready handshake, flush and backpressure.

---
 rtl/decode_stage.sv | 187 ++++++++++++++++++
 tb/tb_decode_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: one-entry registered RV32 decode stage (ID/EX register).
// Decodes add/sub/and/or, addi/andi/ori, lw, sw and beq into the shared
// ALU-op / operand-source / write-back-source encodings.
// Optional build macro: DECODE_ILLEGAL_TRAP_EN. When it is defined, undecodable
// words are passed downstream with illegal=1. When it is not defined, they are
// consumed and dropped.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so a held bundle is replaced in the
// same cycle it is accepted downstream. While out_valid && !out_ready, the
// bundle holds stable. flush drops the held bundle and any incoming word.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      alu_op,
  output logic            alu_src,
  output logic            reg_src,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            illegal
);

  localparam logic [2:0] ALU_ADD = 3'b111;
  localparam logic [2:0] ALU_SUB = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;

  logic            dec_legal;
  logic [2:0]      dec_alu_op;
  logic            dec_alu_src;
  logic            dec_reg_src;
  logic            dec_reg_write;
  logic            dec_mem_read;
  logic            dec_mem_write;
  logic            dec_branch;
  logic [XLEN-1:0] dec_imm;
  logic            load_ok;
  logic            load;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};

  // Instruction decode. The defaults are the illegal-instruction bundle:
  // ADD, REG, ALU, imm 0, and no strobes. sw and beq have no write-back,
  // so reg_src stays at its default of ALU for them.
  always_comb begin
    dec_legal     = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_alu_src   = 1'b0;
    dec_reg_src   = 1'b1;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_imm       = '0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110)) begin
          dec_legal     = 1'b1;
          dec_reg_write = 1'b1;
          dec_alu_op    = (funct3 == 3'b000) ? ALU_ADD : (funct3 == 3'b111) ? ALU_AND : ALU_OR;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal     = 1'b1;
          dec_reg_write = 1'b1;
          dec_alu_op    = ALU_SUB;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110) begin
          dec_legal     = 1'b1;
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_imm       = imm_i;
          dec_alu_op    = (funct3 == 3'b000) ? ALU_ADD : (funct3 == 3'b111) ? ALU_AND : ALU_OR;
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          dec_legal     = 1'b1;
          dec_reg_write = 1'b1;
          dec_mem_read  = 1'b1;
          dec_alu_src   = 1'b1;
          dec_reg_src   = 1'b0;
          dec_imm       = imm_i;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          dec_legal     = 1'b1;
          dec_mem_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_imm       = imm_s;
        end
      end
      7'b1100011: begin
        if (funct3 == 3'b000) begin
          dec_legal  = 1'b1;
          dec_branch = 1'b1;
          dec_alu_op = ALU_SUB;
          dec_imm    = imm_b;
        end
      end
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign load_ok = 1'b1;
`else
  assign load_ok = dec_legal;
`endif

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush && load_ok;

  // ID/EX output register: reset and flush clear it, load replaces it,
  // and a downstream accept without a new load empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      alu_op    <= ALU_SUB;
      alu_src   <= 1'b0;
      reg_src   <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      rs1       <= in_instr[19:15];
      rs2       <= in_instr[24:20];
      rd        <= in_instr[11:7];
      imm       <= dec_imm;
      alu_op    <= dec_alu_op;
      alu_src   <= dec_alu_src;
      reg_src   <= dec_reg_src;
      reg_write <= dec_reg_write;
      mem_read  <= dec_mem_read;
      mem_write <= dec_mem_write;
      branch    <= dec_branch;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal   <= !dec_legal;
`else
      illegal   <= 1'b0;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks from the decode test plan, followed by
// randomized traffic checked against an instruction-level reference decoder
// and a one-deep expected queue.
module tb_decode_stage;

  localparam int W = 89;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [2:0]  alu_op;
  logic        alu_src, reg_src, reg_write, mem_read, mem_write, branch, illegal;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
    .alu_src(alu_src), .reg_src(reg_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .illegal(illegal)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {out_pc, rs1, rs2, rd, imm, alu_op, alu_src, reg_src,
            reg_write, mem_read, mem_write, branch, illegal};
  endfunction

  // Reference decoder. It returns {loadable, bundle}. The immediates are
  // rebuilt from the instruction word using signed integer arithmetic.
  function automatic logic [W:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    int v;
    logic [31:0] im;
    logic [2:0] op;
    logic asrc, rsrc, rw, mr, mw, br, ok, ld, ill;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    v = $signed(ins);
    ok = 0; im = 0; op = 3'b111; asrc = 0; rsrc = 1; rw = 0; mr = 0; mw = 0; br = 0;
    if (opc == 7'h33 && f7 == 7'h00 && (f3 == 0 || f3 == 7 || f3 == 6)) begin
      ok = 1; rw = 1; op = (f3 == 0) ? 3'b111 : (f3 == 7) ? 3'b001 : 3'b011;
    end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 0) begin
      ok = 1; rw = 1; op = 3'b000;
    end else if (opc == 7'h13 && (f3 == 0 || f3 == 7 || f3 == 6)) begin
      ok = 1; rw = 1; asrc = 1; im = v >>> 20;
      op = (f3 == 0) ? 3'b111 : (f3 == 7) ? 3'b001 : 3'b011;
    end else if (opc == 7'h03 && f3 == 2) begin
      ok = 1; rw = 1; mr = 1; asrc = 1; rsrc = 0; im = v >>> 20;
    end else if (opc == 7'h23 && f3 == 2) begin
      ok = 1; mw = 1; asrc = 1;
      im = 32'(((v >>> 25) <<< 5) + int'(ins[11:7]));
    end else if (opc == 7'h63 && f3 == 0) begin
      ok = 1; br = 1; op = 3'b000;
      im = 32'(((v >>> 31) <<< 12) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    ld = 1; ill = !ok;
`else
    ld = ok; ill = 0;
`endif
    return {ld, pc, ins[19:15], ins[24:20], ins[11:7], im, op, asrc, rsrc, rw, mr, mw, br, ill};
  endfunction

  // driver: apply one cycle of inputs, advance the model, and check outputs.
  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                             input logic fl, input logic ordy);
    logic [W:0] d;
    logic acc;
    logic had;
    in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    check("in_ready", in_ready, (exp_q.size() == 0) || ordy);
    had = exp_q.size() != 0;
    acc = v && (!had || ordy);
    d = ref_decode(ins, pc);
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc && d[W]) begin exp_q.delete(); exp_q.push_back(d[W-1:0]); end
    else if (had && ordy) exp_q.delete();
    #1;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("bundle", observed(), exp_q[0]);
    else if (fl) check("flush_strobes", {reg_write, mem_read, mem_write, branch, illegal}, 5'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 4))
          0: r[14:12] = 3'd0; 1: r[14:12] = 3'd7; 2: r[14:12] = 3'd6; 3: r[14:12] = 3'd0;
          default: ;
        endcase
        if ($urandom_range(0, 5) != 0) r[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
      end
      2, 3: begin
        r[6:0] = 7'h13;
        case ($urandom_range(0, 3))
          0: r[14:12] = 3'd0; 1: r[14:12] = 3'd7; 2: r[14:12] = 3'd6;
          default: ;
        endcase
      end
      4: begin r[6:0] = 7'h03; if ($urandom_range(0, 4) != 0) r[14:12] = 3'd2; end
      5: begin r[6:0] = 7'h23; if ($urandom_range(0, 4) != 0) r[14:12] = 3'd2; end
      6: begin r[6:0] = 7'h63; if ($urandom_range(0, 4) != 0) r[14:12] = 3'd0; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_bundle", observed(), '0);
    check("reset_in_ready", in_ready, 1'b1);

    // add x3,x1,x2
    drive_cycle(1, 32'h002081B3, 32'h100, 0, 1);
    check("add_regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd3});
    check("add_ctrl", {alu_op, alu_src, reg_src, reg_write}, {3'b111, 1'b0, 1'b1, 1'b1});
    check("add_imm", imm, 32'h0);

    // sub then addi back to back
    drive_cycle(1, 32'h402081B3, 32'h104, 0, 1);
    check("sub_alu_op", alu_op, 3'b000);
    drive_cycle(1, 32'hFFF00293, 32'h108, 0, 1);
    check("addi_fields", {rd, imm, alu_src, alu_op}, {5'd5, 32'hFFFFFFFF, 1'b1, 3'b111});
    check("addi_valid", out_valid, 1'b1);

    // lw held under backpressure, next instruction waiting
    drive_cycle(1, 32'h00812303, 32'h10C, 0, 1);
    repeat (3) begin
      drive_cycle(1, 32'h002081B3, 32'h110, 0, 0);
      check("lw_held", {mem_read, reg_src, imm}, {1'b1, 1'b0, 32'd8});
    end
    drive_cycle(1, 32'h002081B3, 32'h110, 0, 1);
    check("after_stall_rd", rd, 5'd3);

    // sw, then the same sw under flush
    drive_cycle(1, 32'h00612623, 32'h114, 0, 1);
    check("sw_fields", {mem_write, reg_write, rs1, rs2, imm}, {1'b1, 1'b0, 5'd2, 5'd6, 32'd12});
    drive_cycle(1, 32'h00612623, 32'h118, 1, 1);
    check("flush_valid", out_valid, 1'b0);

    // all-zero word is illegal
    drive_cycle(1, 32'h00000000, 32'h11C, 0, 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("illegal_trap", {out_valid, illegal, reg_write}, 3'b110);
`else
    check("illegal_drop", {out_valid, in_ready}, 2'b01);
`endif

    // asynchronous reset while a bundle is stalled
    drive_cycle(1, 32'h00812303, 32'h120, 0, 1);
    drive_cycle(0, 32'h0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_strobes", {reg_write, mem_read, mem_write, branch}, 4'b0);
    exp_q.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, rand_instr(), {$urandom_range(0, 32'h3FFF), 2'b00},
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
